// File: rtl/keypad_fifo_encoder.sv
// Push-button front end: synchronise raw key lines, priority-encode, debounce the code,
// and queue one event per debounced press in a small valid/ready FIFO.
module keypad_fifo_encoder #(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_KEYS-1:0]             opciones,
  input  logic                          limpiar,
  input  logic                          listo,
  output logic [CODE_W-1:0]             numero,
  output logic                          valido,
  output logic [CODE_W-1:0]             tecla_actual,
  output logic [$clog2(FIFO_DEPTH):0]   cuenta,
  output logic                          desborde
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CODE_W-1:0] NO_KEY   = CODE_W'(N_KEYS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]    FULL     = (PTR_W + 1)'(FIFO_DEPTH);

  logic [N_KEYS-1:0] sync_a;
  logic [N_KEYS-1:0] sinc;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] pend;
  logic [CODE_W-1:0] estable;
  logic [CNT_W-1:0]  cnt;
  logic              commit;
  logic              evento;

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;
  logic              push;
  logic              lleno;
  logic              drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sinc   <= '0;
    end else begin
      sync_a <= opciones;
      sinc   <= sync_a;
    end
  end

  // Lowest index wins: scan downward so the last hit is the lowest set bit.
  always_comb begin
    cand = NO_KEY;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (sinc[i]) cand = CODE_W'(i);
    end
  end

  assign commit = (cand == pend) && (pend != estable) && (cnt == CNT_LAST);
  assign evento = commit && (pend != NO_KEY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= NO_KEY;
      estable <= NO_KEY;
      cnt     <= '0;
    end else if (cand != pend) begin
      pend <= cand;
      cnt  <= '0;
    end else if (pend != estable) begin
      if (cnt == CNT_LAST) begin
        estable <= pend;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  assign valido = (cuenta != '0);
  assign lleno  = (cuenta == FULL);
  assign pop    = valido && listo;
  assign push   = evento && (!lleno || pop);
  assign drop   = evento && lleno && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cuenta   <= '0;
      desborde <= 1'b0;
    end else if (limpiar) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cuenta   <= '0;
      desborde <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cuenta <= cuenta + (PTR_W + 1)'(1);
        2'b01:   cuenta <= cuenta - (PTR_W + 1)'(1);
        default: cuenta <= cuenta;
      endcase
      if (drop) desborde <= 1'b1;
    end
  end

  // Storage needs no reset: numero is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !limpiar) mem[wr_ptr] <= pend;
  end

  assign numero       = valido ? mem[rd_ptr] : NO_KEY;
  assign tecla_actual = estable;

endmodule
